falafel_mem_responder: RTL and testbench

Synthesizable memory-side responder for the falafel allocator's memory port. It accepts falafel's memory requests (`mem_req_*`), services them from an internal word-addressed array, and returns read data on the `mem_resp_*` channel after a programmable latency. It is used as the backing store in integration tests and as a small on-chip heap in FPGA builds.

---
 rtl/falafel_mem_responder_if.sv | 26 ++
 rtl/falafel_mem_responder.sv | 111 +++++++++++
 tb/tb_falafel_mem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/falafel_mem_responder_if.sv
// Memory request/response channel between the falafel allocator (master)
// and its backing-store responder (slave).
interface falafel_mem_responder_if #(
  parameter int DATA_W = 64
);
  logic              mem_req_val_i;
  logic              mem_req_rdy_o;
  logic              mem_req_is_write_i;
  logic [DATA_W-1:0] mem_req_addr_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic              mem_resp_val_o;
  logic              mem_resp_rdy_i;
  logic [DATA_W-1:0] mem_resp_data_o;

  modport master (
    output mem_req_val_i, mem_req_is_write_i, mem_req_addr_i, mem_req_data_i,
    output mem_resp_rdy_i,
    input  mem_req_rdy_o, mem_resp_val_o, mem_resp_data_o
  );

  modport slave (
    input  mem_req_val_i, mem_req_is_write_i, mem_req_addr_i, mem_req_data_i,
    input  mem_resp_rdy_i,
    output mem_req_rdy_o, mem_resp_val_o, mem_resp_data_o
  );
endinterface

// File: rtl/falafel_mem_responder.sv
// Word-addressed memory responder for falafel: single outstanding read,
// programmable read latency, sticky out-of-range error flag.
module falafel_mem_responder #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  falafel_mem_responder_if.slave  bus,
  output logic                    err_o
);

  localparam int ADDR_LSB = $clog2(DATA_W / 8);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  word_idx;
  logic              in_range;
  logic              req_fire;
  logic              wr_fire;
  logic              rd_fire;

  // Byte offset bits are dropped; anything above the index must be zero.
  assign word_idx = bus.mem_req_addr_i[ADDR_LSB +: IDX_W];
  assign in_range = (bus.mem_req_addr_i >> (ADDR_LSB + IDX_W)) == '0;
  assign req_fire = bus.mem_req_val_i && (state_q == IDLE);
  assign wr_fire  = req_fire && bus.mem_req_is_write_i;
  assign rd_fire  = req_fire && !bus.mem_req_is_write_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the array has no reset; only control state needs a known value, and contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire && in_range) begin
      mem_q[word_idx] <= bus.mem_req_data_i;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;

    if (req_fire && !in_range) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rd_fire) begin
          resp_data_d = in_range ? mem_q[word_idx] : '1;
          cnt_d       = CNT_LOAD;
          state_d     = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.mem_resp_rdy_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, never from inputs.
  always_comb begin
    bus.mem_req_rdy_o   = (state_q == IDLE);
    bus.mem_resp_val_o  = (state_q == RESP);
    bus.mem_resp_data_o = resp_data_q;
    err_o               = err_q;
  end

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed bench for falafel_mem_responder: a LATENCY=2 and a LATENCY=1
// instance share one stimulus channel selected by sel.
module tb_falafel_mem_responder;

  localparam int DATA_W = 64;
  localparam logic [63:0] BEEF = 64'h0000_0000_DEAD_BEEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        sel      = 1'b0;
  logic        req_val  = 1'b0;
  logic        req_we   = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic        resp_rdy = 1'b1;

  falafel_mem_responder_if #(.DATA_W(DATA_W)) bus0 ();
  falafel_mem_responder_if #(.DATA_W(DATA_W)) bus1 ();

  assign bus0.mem_req_val_i      = req_val && !sel;
  assign bus0.mem_req_is_write_i = req_we;
  assign bus0.mem_req_addr_i     = req_addr;
  assign bus0.mem_req_data_i     = req_data;
  assign bus0.mem_resp_rdy_i     = resp_rdy;
  assign bus1.mem_req_val_i      = req_val && sel;
  assign bus1.mem_req_is_write_i = req_we;
  assign bus1.mem_req_addr_i     = req_addr;
  assign bus1.mem_req_data_i     = req_data;
  assign bus1.mem_resp_rdy_i     = resp_rdy;

  logic err0, err1;

  falafel_mem_responder #(.DATA_W(DATA_W), .DEPTH(256), .LATENCY(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0), .err_o(err0)
  );
  falafel_mem_responder #(.DATA_W(DATA_W), .DEPTH(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1), .err_o(err1)
  );

  wire        rdy   = sel ? bus1.mem_req_rdy_o   : bus0.mem_req_rdy_o;
  wire        rval  = sel ? bus1.mem_resp_val_o  : bus0.mem_resp_val_o;
  wire [63:0] rdata = sel ? bus1.mem_resp_data_o : bus0.mem_resp_data_o;
  wire        err   = sel ? err1 : err0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // All helpers start and end at a falling edge.
  task automatic wait_rdy();
    int n = 0;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_rdy_timeout: rdy=%b after %0d cycles, required 1", rdy, n);
    end
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d);
    req_we = 1'b1; req_addr = a; req_data = d; req_val = 1'b1;
    wait_rdy();
    @(negedge clk);
    req_val = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] a, output logic [63:0] d, output int lat);
    req_we = 1'b0; req_addr = a; req_val = 1'b1;
    wait_rdy();
    @(negedge clk);
    req_val = 1'b0;
    lat = 1;
    while (rval !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (rval !== 1'b1) begin
      checks++; errors++;
      $display("FAIL resp_timeout: val=%b after %0d cycles, required 1", rval, lat);
    end
    d = rdata;
    if (resp_rdy) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus0.mem_req_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b required 1", bus0.mem_req_rdy_o); end
    checks++; if (bus0.mem_resp_val_o !== 1'b0) begin errors++; $display("FAIL reset_val: got %b required 0", bus0.mem_resp_val_o); end
    checks++; if (bus0.mem_resp_data_o !== 64'h0) begin errors++; $display("FAIL reset_data: got %h required 0", bus0.mem_resp_data_o); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err0); end
    checks++; if (bus1.mem_resp_val_o !== 1'b0) begin errors++; $display("FAIL reset_val_l1: got %b required 0", bus1.mem_resp_val_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL post_reset_rdy: got %b required 1", rdy); end
  endtask

  task automatic test_basic();
    do_write(64'h10, BEEF);
    req_we = 1'b0; req_addr = 64'h10; req_val = 1'b1;
    wait_rdy();
    @(negedge clk);
    req_val = 1'b0;
    checks++; if (rval !== 1'b0) begin errors++; $display("FAIL basic_val_t1: got %b required 0", rval); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy_t1: got %b required 0", rdy); end
    @(negedge clk);
    checks++; if (rval !== 1'b1) begin errors++; $display("FAIL basic_val_t2: got %b required 1", rval); end
    checks++; if (rdata !== BEEF) begin errors++; $display("FAIL basic_data: got %h required %h", rdata, BEEF); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_rdy_t2: got %b required 0", rdy); end
    @(negedge clk);
    checks++; if (rdy !== 1'b1 || rval !== 1'b0) begin errors++; $display("FAIL basic_after_hs: rdy=%b val=%b required rdy=1 val=0", rdy, rval); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    int lat;
    int n = 0;
    resp_rdy = 1'b0;
    req_we = 1'b0; req_addr = 64'h10; req_val = 1'b1;
    wait_rdy();
    @(negedge clk);
    req_val = 1'b0;
    while (rval !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_we = 1'b1; req_addr = 64'h18; req_data = 64'h1234; req_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rval !== 1'b1 || rdata !== BEEF || rdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_%0d: val=%b data=%h rdy=%b required val=1 data=%h rdy=0", i, rval, rdata, rdy, BEEF);
      end
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    checks++; if (rdy !== 1'b1 || rval !== 1'b0) begin errors++; $display("FAIL bp_after_hs: rdy=%b val=%b required rdy=1 val=0", rdy, rval); end
    @(negedge clk);
    req_val = 1'b0; req_we = 1'b0;
    do_read(64'h18, d, lat);
    checks++; if (d !== 64'h1234) begin errors++; $display("FAIL bp_stalled_write: got %h required %h", d, 64'h1234); end
  endtask

  task automatic test_misaligned();
    logic [63:0] d;
    int lat;
    do_write(64'h08, 64'hAAAA_0001);
    do_write(64'h0F, 64'hBBBB_0002);
    do_read(64'h0C, d, lat);
    checks++; if (d !== 64'hBBBB_0002) begin errors++; $display("FAIL misaligned_read: got %h required %h", d, 64'hBBBB_0002); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL misaligned_latency: got %0d required 2", lat); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] d;
    int lat;
    do_write(64'h00, 64'h5555);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_before: got %b required 0", err); end
    do_write(64'h800, 64'hBAD);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b required 1", err); end
    do_read(64'h00, d, lat);
    checks++; if (d !== 64'h5555) begin errors++; $display("FAIL oor_array_unchanged: got %h required %h", d, 64'h5555); end
    do_read(64'h800, d, lat);
    checks++; if (d !== '1) begin errors++; $display("FAIL oor_read_ones: got %h required all ones", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_read_latency: got %0d required 2", lat); end
    do_read(64'h10, d, lat);
    checks++; if (d !== BEEF) begin errors++; $display("FAIL oor_followup_read: got %h required %h", d, BEEF); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b required 1", err); end
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] d;
    int lat;
    int stale = 0;
    req_we = 1'b0; req_addr = 64'h10; req_val = 1'b1;
    wait_rdy();
    @(negedge clk);
    req_val = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (rval !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL rst_wait_outputs: val=%b rdy=%b required val=0 rdy=1", rval, rdy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_wait_err: got %b required 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rval !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rst_wait_stale: got %0d stale cycles required 0", stale); end
    do_read(64'h10, d, lat);
    checks++; if (d !== BEEF) begin errors++; $display("FAIL rst_wait_retained: got %h required %h", d, BEEF); end
  endtask

  task automatic test_latency1();
    logic [63:0] d;
    int lat;
    int resp_cnt = 0;
    int bad = 0;
    sel = 1'b1;
    do_write(64'h10, BEEF);
    do_read(64'h10, d, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l1_latency: got %0d required 1", lat); end
    checks++; if (d !== BEEF) begin errors++; $display("FAIL l1_data: got %h required %h", d, BEEF); end
    req_we = 1'b0; req_addr = 64'h10; req_val = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rval === 1'b1) begin
        resp_cnt++;
        if (rdata !== BEEF) bad++;
        if (resp_cnt == 10) req_val = 1'b0;
      end
    end
    checks++; if (resp_cnt !== 10) begin errors++; $display("FAIL l1_b2b_count: got %0d required 10", resp_cnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL l1_b2b_data: got %0d bad responses required 0", bad); end
    checks++; if (rdy !== 1'b1 || rval !== 1'b0) begin errors++; $display("FAIL l1_b2b_end: rdy=%b val=%b required rdy=1 val=0", rdy, rval); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_misaligned();
    test_out_of_range();
    test_reset_in_wait();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
